// File: rtl/cache_ctrl_assoc_pkg.sv
// Shared types and address-slicing helpers for the set-associative cache controller.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITE_BACK,
    ALLOCATE
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

  // Extract a w-bit field starting at bit lsb from a zero-extended address.
  function automatic logic [63:0] addr_field(input logic [63:0] a,
                                             input int unsigned lsb,
                                             input int unsigned w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (a >> lsb) & mask;
  endfunction

  function automatic logic [63:0] addr_index(input logic [63:0] a,
                                             input int unsigned off_w,
                                             input int unsigned idx_w);
    return addr_field(a, off_w, idx_w);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] a,
                                           input int unsigned addr_w,
                                           input int unsigned off_w,
                                           input int unsigned idx_w);
    return addr_field(a, off_w + idx_w, addr_w - off_w - idx_w);
  endfunction

endpackage

// File: rtl/cache_ctrl_assoc_if.sv
// CPU request port plus memory transfer port of the cache controller.
interface cache_ctrl_assoc_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned WAY_W  = 1
);
  logic              read_req;
  logic              write_req;
  logic [ADDR_W-1:0] addr;
  logic              mem_ready;
  logic              req_ready;
  logic              done;
  logic              hit;
  logic              evict;
  logic              write_back;
  logic              allocate;
  logic [ADDR_W-1:0] mem_addr;
  logic [WAY_W-1:0]  victim_way;

  // Requester / memory side.
  modport master (
    output read_req, write_req, addr, mem_ready,
    input  req_ready, done, hit, evict, write_back, allocate, mem_addr, victim_way
  );

  // Controller side.
  modport slave (
    input  read_req, write_req, addr, mem_ready,
    output req_ready, done, hit, evict, write_back, allocate, mem_addr, victim_way
  );
endinterface

// File: rtl/cache_ctrl_assoc_lru_age.sv
// Next-age vector for one set after touching one way (true LRU by age ranking).
module cache_lru_age
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned WAY_W = 1
) (
  input  logic [WAYS-1:0][WAY_W-1:0] ages_i,
  input  logic [WAY_W-1:0]           touch_i,
  output logic [WAYS-1:0][WAY_W-1:0] ages_o
);

  logic [WAY_W-1:0] touched_age;

  // Younger ways than the touched one age by one; touched way becomes youngest.
  always_comb begin
    touched_age = ages_i[touch_i];
    ages_o      = ages_i;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (ages_i[w] < touched_age) begin
        ages_o[w] = ages_i[w] + WAY_W'(1);
      end
    end
    ages_o[touch_i] = '0;
  end

endmodule

// File: rtl/cache_ctrl_assoc.sv
// N-way set-associative write-back/write-allocate cache tag and control engine.
module cache_ctrl_assoc
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned OFFSET_W = 4,
  parameter int unsigned SETS     = 16,
  parameter int unsigned WAYS     = 2
) (
  input  logic              clk,
  input  logic              rst,
  cache_ctrl_assoc_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned TAG_W = ADDR_W - OFFSET_W - IDX_W;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WAY_W-1:0]  victim_q, victim_d;

  logic [SETS-1:0][WAYS-1:0]             valid_q, valid_d;
  logic [SETS-1:0][WAYS-1:0]             dirty_q, dirty_d;
  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [SETS-1:0][WAYS-1:0][WAY_W-1:0]  age_q, age_d;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [ADDR_W-1:0] req_line;
  logic [ADDR_W-1:0] victim_line;
  logic [WAY_W-1:0]  line_way;

  logic              hit_any;
  logic [WAY_W-1:0]  hit_way;
  logic              inv_found;
  logic [WAY_W-1:0]  victim_sel;
  logic [WAY_W-1:0]  max_age;
  logic              victim_valid;
  logic              victim_dirty;

  logic [WAY_W-1:0]            touch_way;
  logic [WAYS-1:0][WAY_W-1:0]  next_ages;

  logic              req_ready;
  logic              done;
  logic              hit;
  logic              evict;
  logic              write_back;
  logic              allocate;
  logic [ADDR_W-1:0] mem_addr;
  logic [WAY_W-1:0]  victim_way;

  assign req_idx  = IDX_W'(addr_index(64'(addr_q), OFFSET_W, IDX_W));
  assign req_tag  = TAG_W'(addr_tag(64'(addr_q), ADDR_W, OFFSET_W, IDX_W));
  assign req_line = {req_tag, req_idx, {OFFSET_W{1'b0}}};

  // The victim way is still being chosen in COMPARE; afterwards it is the latched one.
  assign line_way    = (state_q == COMPARE) ? victim_sel : victim_q;
  assign victim_line = {tag_q[req_idx][line_way], req_idx, {OFFSET_W{1'b0}}};

  // Tag match across all ways of the addressed set.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit_any && valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim choice: lowest-index invalid way, otherwise the oldest way.
  always_comb begin
    inv_found  = 1'b0;
    victim_sel = '0;
    max_age    = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!inv_found && !valid_q[req_idx][w]) begin
        inv_found  = 1'b1;
        victim_sel = WAY_W'(w);
      end
    end
    if (!inv_found) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_q[req_idx][w] > max_age) begin
          max_age    = age_q[req_idx][w];
          victim_sel = WAY_W'(w);
        end
      end
    end
    victim_valid = valid_q[req_idx][victim_sel];
    victim_dirty = dirty_q[req_idx][victim_sel];
  end

  // A hit touches the matching way; a fill touches the latched victim.
  assign touch_way = (state_q == COMPARE) ? hit_way : victim_q;

  cache_lru_age #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_lru (
    .ages_i (age_q[req_idx]),
    .touch_i(touch_way),
    .ages_o (next_ages)
  );

  // Next-state, array updates and outputs of the request FSM.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    victim_d   = victim_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    age_d      = age_q;
    req_ready  = 1'b0;
    done       = 1'b0;
    hit        = 1'b0;
    evict      = 1'b0;
    write_back = 1'b0;
    allocate   = 1'b0;
    mem_addr   = '0;
    victim_way = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.read_req || bus.write_req) begin
          addr_d  = bus.addr;
          op_d    = bus.write_req ? OP_WRITE : OP_READ;
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        if (hit_any) begin
          done       = 1'b1;
          hit        = 1'b1;
          victim_way = hit_way;
          mem_addr   = req_line;
          age_d[req_idx] = next_ages;
          if (op_q == OP_WRITE) begin
            dirty_d[req_idx][hit_way] = 1'b1;
          end
          state_d = IDLE;
        end else begin
          victim_d   = victim_sel;
          victim_way = victim_sel;
          evict      = victim_valid;
          if (victim_valid && victim_dirty) begin
            mem_addr = victim_line;
            state_d  = WRITE_BACK;
          end else begin
            mem_addr = req_line;
            state_d  = ALLOCATE;
          end
        end
      end

      WRITE_BACK: begin
        write_back = 1'b1;
        victim_way = victim_q;
        mem_addr   = victim_line;
        if (bus.mem_ready) begin
          dirty_d[req_idx][victim_q] = 1'b0;
          state_d = ALLOCATE;
        end
      end

      ALLOCATE: begin
        allocate   = 1'b1;
        victim_way = victim_q;
        mem_addr   = req_line;
        if (bus.mem_ready) begin
          tag_d[req_idx][victim_q]   = req_tag;
          valid_d[req_idx][victim_q] = 1'b1;
          dirty_d[req_idx][victim_q] = (op_q == OP_WRITE);
          age_d[req_idx]             = next_ages;
          done    = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and tag/valid/dirty/age storage; ages reset to the identity ranking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_READ;
      addr_q   <= '0;
      victim_q <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      tag_q    <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      victim_q <= victim_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      tag_q    <= tag_d;
      age_q    <= age_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.done       = done;
  assign bus.hit        = hit;
  assign bus.evict      = evict;
  assign bus.write_back = write_back;
  assign bus.allocate   = allocate;
  assign bus.mem_addr   = mem_addr;
  assign bus.victim_way = victim_way;

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Directed bench for cache_ctrl_assoc with the default 24-bit, 16-set, 2-way configuration.
module tb_cache_ctrl_assoc;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  cache_ctrl_assoc_if #(.ADDR_W(24), .WAY_W(1)) bus ();

  cache_ctrl_assoc #(
    .ADDR_W  (24),
    .OFFSET_W(4),
    .SETS    (16),
    .WAYS    (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns just after the acceptance edge (in COMPARE).
  task automatic issue(input string tag, input logic rd, input logic wr, input logic [23:0] a);
    @(negedge clk);
    chk1({tag, "_req_ready"}, bus.req_ready, 1'b1);
    bus.read_req  = rd;
    bus.write_req = wr;
    bus.addr      = a;
    @(negedge clk);
    bus.read_req  = 1'b0;
    bus.write_req = 1'b0;
    #1;
  endtask

  // Complete an ALLOCATE phase with a one-cycle mem_ready.
  task automatic fill(input string tag);
    bus.mem_ready = 1'b1;
    #1;
    chk1({tag, "_fill_done"}, bus.done, 1'b1);
    chk1({tag, "_fill_hit"}, bus.hit, 1'b0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk1({tag, "_idle_ready"}, bus.req_ready, 1'b1);
    chk1({tag, "_idle_done"}, bus.done, 1'b0);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    bus.read_req  = 1'b0;
    bus.write_req = 1'b0;
    bus.addr      = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_req_ready", bus.req_ready, 1'b1);
    chk1("rst_done", bus.done, 1'b0);
    chk1("rst_evict", bus.evict, 1'b0);
    chk1("rst_alloc", bus.allocate, 1'b0);
    chk1("rst_wb", bus.write_back, 1'b0);
    chk24("rst_mem_addr", bus.mem_addr, 24'h000000);
    rst = 1'b0;

    // 1: cold read fills invalid way 0
    issue("t1", 1'b1, 1'b0, 24'h123456);
    chk1("t1_cmp_done", bus.done, 1'b0);
    chk1("t1_cmp_evict", bus.evict, 1'b0);
    chk1("t1_cmp_victim", bus.victim_way, 1'b0);
    @(negedge clk); #1;
    chk1("t1_alloc", bus.allocate, 1'b1);
    chk1("t1_wb", bus.write_back, 1'b0);
    chk24("t1_mem_addr", bus.mem_addr, 24'h123450);
    @(negedge clk); #1;
    chk1("t1_alloc_held", bus.allocate, 1'b1);
    chk1("t1_alloc_done", bus.done, 1'b0);
    fill("t1");

    // 2: repeat read hits one cycle after acceptance
    issue("t2", 1'b1, 1'b0, 24'h123456);
    chk1("t2_done", bus.done, 1'b1);
    chk1("t2_hit", bus.hit, 1'b1);
    chk1("t2_alloc", bus.allocate, 1'b0);
    @(negedge clk); #1;
    chk1("t2_ready", bus.req_ready, 1'b1);
    chk1("t2_alloc_after", bus.allocate, 1'b0);
    chk1("t2_wb_after", bus.write_back, 1'b0);

    // 3: write hit dirties way 0; new tag fills invalid way 1
    issue("t3w", 1'b0, 1'b1, 24'h123456);
    chk1("t3w_done", bus.done, 1'b1);
    chk1("t3w_hit", bus.hit, 1'b1);
    issue("t3r", 1'b1, 1'b0, 24'h222256);
    chk1("t3r_evict", bus.evict, 1'b0);
    chk1("t3r_victim", bus.victim_way, 1'b1);
    chk1("t3r_done", bus.done, 1'b0);
    @(negedge clk); #1;
    chk1("t3r_alloc", bus.allocate, 1'b1);
    chk24("t3r_mem_addr", bus.mem_addr, 24'h222250);
    fill("t3r");

    // 4: LRU way 0 is dirty -> evict, write-back, then fill
    issue("t4", 1'b1, 1'b0, 24'h333356);
    chk1("t4_evict", bus.evict, 1'b1);
    chk1("t4_victim", bus.victim_way, 1'b0);
    chk1("t4_cmp_done", bus.done, 1'b0);
    @(negedge clk); #1;
    chk1("t4_wb", bus.write_back, 1'b1);
    chk1("t4_wb_alloc", bus.allocate, 1'b0);
    chk1("t4_wb_evict", bus.evict, 1'b0);
    chk24("t4_wb_addr", bus.mem_addr, 24'h123450);
    bus.mem_ready = 1'b1;
    #1;
    chk1("t4_wb_done", bus.done, 1'b0);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk1("t4_alloc", bus.allocate, 1'b1);
    chk1("t4_alloc_wb", bus.write_back, 1'b0);
    chk24("t4_alloc_addr", bus.mem_addr, 24'h333350);
    chk1("t4_alloc_victim", bus.victim_way, 1'b0);
    fill("t4");

    // 5: LRU way 1 is clean -> evict without write-back
    issue("t5", 1'b1, 1'b0, 24'h123456);
    chk1("t5_evict", bus.evict, 1'b1);
    chk1("t5_victim", bus.victim_way, 1'b1);
    @(negedge clk); #1;
    chk1("t5_wb", bus.write_back, 1'b0);
    chk1("t5_alloc", bus.allocate, 1'b1);
    chk24("t5_mem_addr", bus.mem_addr, 24'h123450);
    fill("t5");

    // 6: reset in WRITE_BACK aborts, then cache behaves as cold
    issue("t6a", 1'b0, 1'b1, 24'h123456);
    chk1("t6a_hit", bus.hit, 1'b1);
    issue("t6b", 1'b1, 1'b0, 24'h333356);
    chk1("t6b_hit", bus.hit, 1'b1);
    issue("t6c", 1'b1, 1'b0, 24'h444456);
    chk1("t6c_evict", bus.evict, 1'b1);
    chk1("t6c_victim", bus.victim_way, 1'b1);
    @(negedge clk); #1;
    chk1("t6c_wb", bus.write_back, 1'b1);
    chk24("t6c_wb_addr", bus.mem_addr, 24'h123450);
    #2;
    rst = 1'b1;
    #1;
    chk1("t6_rst_wb", bus.write_back, 1'b0);
    chk1("t6_rst_done", bus.done, 1'b0);
    chk1("t6_rst_ready", bus.req_ready, 1'b1);
    chk24("t6_rst_mem_addr", bus.mem_addr, 24'h000000);
    @(negedge clk);
    chk1("t6_rst_hold_done", bus.done, 1'b0);
    rst = 1'b0;
    issue("t6d", 1'b1, 1'b0, 24'h333356);
    chk1("t6d_done", bus.done, 1'b0);
    chk1("t6d_evict", bus.evict, 1'b0);
    chk1("t6d_victim", bus.victim_way, 1'b0);
    @(negedge clk); #1;
    chk1("t6d_alloc", bus.allocate, 1'b1);
    chk24("t6d_mem_addr", bus.mem_addr, 24'h333350);
    fill("t6d");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete (vectors=%0d miscompares=%0d)", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule
